// File: rtl/imu_spi_sequencer.sv
// IMU SPI sequencer: power-up wait, sensor configuration, then
// six-byte gyro rate bursts on each data-ready interrupt.
module imu_spi_sequencer #(
    parameter int unsigned PWR_WAIT_W = 16,
    parameter logic [15:0] CFG0       = 16'h0D02,
    parameter logic [15:0] CFG1       = 16'h1062,
    parameter logic [15:0] CFG2       = 16'h1162,
    parameter logic [7:0]  RD_BASE    = 8'hA2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw,
    output logic        vld,
    output logic        cfg_done
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG_ISSUE,
        CFG_WAIT,
        GAP,
        WAIT_INT,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t                  state, state_n;
    logic [PWR_WAIT_W-1:0]   pwr_cnt, pwr_cnt_n;
    logic [1:0]              cfg_idx, cfg_idx_n;
    logic [2:0]              rd_idx, rd_idx_n;
    logic [15:0]             cmd_n;
    logic [47:0]             shadow, shadow_n;
    logic                    pending, pending_n;
    logic                    cfg_done_n;
    logic                    load;
    logic                    wait_first;
    logic                    done_ok;
    logic                    int_s1, int_s2, int_s3;
    logic                    int_rise;
    logic                    unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];
    assign int_rise     = int_s2 & ~int_s3;
    // The monarch is still clearing done during the cycle after wrt.
    assign done_ok      = done & ~wait_first;

    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        unique case (idx)
            2'd0:    cfg_word = CFG0;
            2'd1:    cfg_word = CFG1;
            default: cfg_word = CFG2;
        endcase
    endfunction

    // INT synchronizer plus edge-detect flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_s1 <= 1'b0;
            int_s2 <= 1'b0;
            int_s3 <= 1'b0;
        end else begin
            int_s1 <= INT;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
        end
    end

    // Sequencer state, counters, command and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PWR_WAIT;
            pwr_cnt    <= '0;
            cfg_idx    <= '0;
            rd_idx     <= '0;
            cmd        <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            cfg_done   <= 1'b0;
            wait_first <= 1'b0;
            ptch       <= '0;
            roll       <= '0;
            yaw        <= '0;
            vld        <= 1'b0;
        end else begin
            state      <= state_n;
            pwr_cnt    <= pwr_cnt_n;
            cfg_idx    <= cfg_idx_n;
            rd_idx     <= rd_idx_n;
            cmd        <= cmd_n;
            shadow     <= shadow_n;
            pending    <= pending_n;
            cfg_done   <= cfg_done_n;
            wait_first <= wrt;
            vld        <= load;
            if (load) begin
                ptch <= shadow_n[15:0];
                roll <= shadow_n[31:16];
                yaw  <= shadow_n[47:32];
            end
        end
    end

    // Next-state, command selection and byte capture.
    always_comb begin
        state_n    = state;
        pwr_cnt_n  = pwr_cnt;
        cfg_idx_n  = cfg_idx;
        rd_idx_n   = rd_idx;
        cmd_n      = cmd;
        shadow_n   = shadow;
        pending_n  = pending;
        cfg_done_n = cfg_done;
        load       = 1'b0;
        wrt        = 1'b0;

        if (int_rise && cfg_done && state != WAIT_INT) begin
            pending_n = 1'b1;
        end

        unique case (state)
            PWR_WAIT: begin
                pwr_cnt_n = pwr_cnt + PWR_WAIT_W'(1);
                if (&pwr_cnt) begin
                    state_n   = CFG_ISSUE;
                    cfg_idx_n = 2'd0;
                    cmd_n     = CFG0;
                end
            end
            CFG_ISSUE: begin
                wrt     = 1'b1;
                state_n = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (done_ok) begin
                    if (cfg_idx != 2'd2) begin
                        cfg_idx_n = cfg_idx + 2'd1;
                        state_n   = GAP;
                    end else begin
                        cfg_done_n = 1'b1;
                        state_n    = WAIT_INT;
                    end
                end
            end
            GAP: begin
                if (cfg_done) begin
                    state_n = RD_ISSUE;
                    cmd_n   = {RD_BASE + {5'd0, rd_idx}, 8'h00};
                end else begin
                    state_n = CFG_ISSUE;
                    cmd_n   = cfg_word(cfg_idx);
                end
            end
            WAIT_INT: begin
                if (int_rise || pending) begin
                    pending_n = 1'b0;
                    rd_idx_n  = 3'd0;
                    state_n   = RD_ISSUE;
                    cmd_n     = {RD_BASE, 8'h00};
                end
            end
            RD_ISSUE: begin
                wrt     = 1'b1;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (done_ok) begin
                    for (int i = 0; i < 6; i++) begin
                        if (rd_idx == 3'(i)) begin
                            shadow_n[i*8 +: 8] = rd_data[7:0];
                        end
                    end
                    if (rd_idx != 3'd5) begin
                        rd_idx_n = rd_idx + 3'd1;
                        state_n  = GAP;
                    end else begin
                        load    = 1'b1;
                        state_n = WAIT_INT;
                    end
                end
            end
            default: state_n = PWR_WAIT;
        endcase
    end

endmodule

// File: tb/tb_imu_spi_sequencer.sv
// Bench for imu_spi_sequencer: SPI monarch model with
// scoreboarded commands and rate outputs.
module tb_imu_spi_sequencer;

    localparam int LAT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic        vld;
    logic        cfg_done;

    imu_spi_sequencer #(
        .PWR_WAIT_W(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch    (ptch),
        .roll    (roll),
        .yaw     (yaw),
        .vld     (vld),
        .cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [47:0] obs,
                         input logic [47:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] cmd_q[$];
    logic [47:0] out_q[$];
    logic [7:0]  tbl[6] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};

    int          cyc = 0;
    int          cnt = 0;
    int          stale = 0;
    int          nb = -1;
    int          cur_k = 0;
    int          done_cyc = 0;
    int          rel_cyc = 0;
    int          vld_cyc = 0;
    int          vld_cnt = 0;
    bit          busy = 0;
    bit          pwr_chk = 0;
    bit          stale_arm = 0;
    bit          b2b_chk = 0;
    bit          cfg_last = 0;
    logic [15:0] cur_cmd = 16'h0000;
    logic [47:0] prev_out = 48'h0;

    // SPI monarch model and output monitor
    initial begin
        logic [47:0] e48;
        logic [15:0] e16;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                busy     = 0;
                done     = 1'b0;
                stale    = 0;
                cfg_last = 0;
            end else begin
                if (cfg_last) begin
                    check("cfg_done_post", 48'(cfg_done), 48'(1));
                    cfg_last = 0;
                end
                if (vld) begin
                    vld_cnt++;
                    vld_cyc = cyc;
                    if (out_q.size() == 0) begin
                        check("vld_sb_size", 48'(out_q.size()), 48'(1));
                    end else begin
                        e48 = out_q.pop_front();
                        check("ptch", 48'(ptch), 48'(e48[15:0]));
                        check("roll", 48'(roll), 48'(e48[31:16]));
                        check("yaw", 48'(yaw), 48'(e48[47:32]));
                    end
                end
                if ({yaw, roll, ptch} != prev_out) begin
                    check("out_change_vld", 48'(vld), 48'(1));
                end
                if (wrt) begin
                    check("wrt_idle", 48'(busy), 48'(0));
                    if (cmd_q.size() == 0) begin
                        check("cmd_sb_size", 48'(cmd_q.size()), 48'(1));
                    end else begin
                        e16 = cmd_q.pop_front();
                        check("cmd", 48'(cmd), 48'(e16));
                    end
                    if (pwr_chk) begin
                        check("pwr_wait", 48'(cyc - rel_cyc), 48'(16));
                        pwr_chk = 0;
                    end else if (cmd != 16'h0D02 && cmd[15:8] != 8'hA2) begin
                        check("gap", 48'(cyc - done_cyc), 48'(2));
                    end
                    if (b2b_chk && cmd == 16'hA200) begin
                        check("pend_start", 48'(cyc - vld_cyc), 48'(1));
                        b2b_chk = 0;
                    end
                    if (cmd[15:8] == 8'hA2) nb++;
                    cur_cmd = cmd;
                    cur_k   = int'(cmd[15:8]) - 162;
                    busy    = 1;
                    cnt     = LAT;
                    if (stale_arm) stale = 2;
                    else done = 1'b0;
                end else begin
                    if (stale > 0) begin
                        stale--;
                        if (stale == 0) done = 1'b0;
                    end
                    if (busy) begin
                        cnt--;
                        if (cnt == 0) begin
                            busy     = 0;
                            done     = 1'b1;
                            done_cyc = cyc;
                            if (cur_k >= 0 && cur_k < 6)
                                rd_data = {8'h00, 8'(tbl[cur_k] + 8'(nb * 3))};
                            else
                                rd_data = 16'h00EE;
                            if (cur_cmd == 16'h1162) begin
                                check("cfg_done_pre", 48'(cfg_done), 48'(0));
                                cfg_last = 1;
                            end
                        end
                    end
                end
            end
            prev_out = {yaw, roll, ptch};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        tick(5);
    endtask

    task automatic push_cfg();
        cmd_q.push_back(16'h0D02);
        cmd_q.push_back(16'h1062);
        cmd_q.push_back(16'h1162);
    endtask

    task automatic push_burst(input int b);
        logic [7:0] o;
        o = 8'(b * 3);
        for (int k = 0; k < 6; k++) cmd_q.push_back({8'(8'hA2 + k), 8'h00});
        out_q.push_back({8'(tbl[5] + o), 8'(tbl[4] + o),
                         8'(tbl[3] + o), 8'(tbl[2] + o),
                         8'(tbl[1] + o), 8'(tbl[0] + o)});
    endtask

    task automatic wait_vld(input int target, input int budget);
        int t = 0;
        while (vld_cnt < target && t < budget) begin
            tick(1);
            t++;
        end
        check("vld_count", 48'(vld_cnt), 48'(target));
    endtask

    task automatic wait_cfg(input int budget);
        int t = 0;
        while (!cfg_done && t < budget) begin
            tick(1);
            t++;
        end
        check("cfg_done", 48'(cfg_done), 48'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wrt"}, 48'(wrt), 48'(0));
        check({tag, "_cmd"}, 48'(cmd), 48'(0));
        check({tag, "_ptch"}, 48'(ptch), 48'(0));
        check({tag, "_roll"}, 48'(roll), 48'(0));
        check({tag, "_yaw"}, 48'(yaw), 48'(0));
        check({tag, "_vld"}, 48'(vld), 48'(0));
        check({tag, "_cfg_done"}, 48'(cfg_done), 48'(0));
    endtask

    // Main stimulus sequence
    initial begin
        int t;
        tick(3);
        check_zero("rst");

        push_cfg();
        rst     = 1'b0;
        rel_cyc = cyc;
        pwr_chk = 1;
        tick(3);
        pulse_int();
        tick(20);
        pulse_int();
        wait_cfg(600);
        tick(30);
        check("no_early_read", 48'(cmd_q.size()), 48'(0));

        push_burst(0);
        pulse_int();
        wait_vld(1, 800);

        push_burst(1);
        push_burst(2);
        pulse_int();
        tick(40);
        pulse_int();
        pulse_int();
        pulse_int();
        wait_vld(2, 800);
        b2b_chk = 1;
        wait_vld(3, 800);
        tick(400);
        check("vld_total", 48'(vld_cnt), 48'(3));
        check("sb_drained", 48'(cmd_q.size()), 48'(0));

        stale_arm = 1;
        push_burst(3);
        pulse_int();
        wait_vld(4, 1000);
        stale_arm = 0;

        push_burst(4);
        pulse_int();
        t = 0;
        while (!(busy && cur_cmd == 16'hA500) && t < 1000) begin
            tick(1);
            t++;
        end
        check("rst_point", 48'(cur_cmd), 48'(16'hA500));
        rst = 1'b1;
        #1;
        check_zero("midrst");
        cmd_q.delete();
        out_q.delete();
        tick(3);
        push_cfg();
        rst     = 1'b0;
        rel_cyc = cyc;
        pwr_chk = 1;
        wait_cfg(600);
        tick(10);

        push_burst(5);
        pulse_int();
        wait_vld(5, 800);
        tick(10);
        check("sb_final", 48'(cmd_q.size() + out_q.size()), 48'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
